// File: rtl/mdio_pkg.sv
// MDIO management-station shared definitions.
// Frame field codes, frame geometry and FSM encoding.
package mdio_pkg;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA       = 2'b10;

  localparam int FRAME_BITS = 32;
  localparam int DATA_BITS  = 16;

  localparam logic [5:0] CNT_TURN = 6'(FRAME_BITS - DATA_BITS);
  localparam logic [5:0] CNT_LAST = 6'(FRAME_BITS);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_RECV = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  function automatic logic is_read(input logic [31:0] f);
    return f[29:28] == OP_READ;
  endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: toggles every HALF_PERIOD clocks while enabled,
// with combinational strobes on the clock edge that moves MDC.
module mdc_gen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          last;

  always_comb begin
    last  = (cnt_q == LAST);
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc  = mdc_q;
  assign rise = en & last & ~mdc_q;
  assign fall = en & last & mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// MDIO initiator: serializes a 32-bit frame on MDIO_OUT and,
// for reads, turns the line around and captures 16 PHY bits.
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        TRANS_DONE,
  output logic        BUSY
);

  state_e      state_q, state_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        en, fall, unused_rise;

  assign en = (state_q == S_SEND) || (state_q == S_RECV);

  mdc_gen #(.HALF_PERIOD(HALF_PERIOD)) u_mdc (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (en),
    .mdc   (MDC),
    .rise  (unused_rise),
    .fall  (fall)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    case (state_q)
      S_IDLE: begin
        if (MDIO_START) begin
          state_d = S_SEND;
          tx_sr_d = T_DATA;
          rx_sr_d = '0;
          cnt_d   = '0;
          rd_d    = is_read(T_DATA);
        end
      end
      S_SEND: begin
        if (fall) begin
          tx_sr_d = {tx_sr_q[30:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
          if (rd_q && cnt_d == CNT_TURN)
            state_d = S_RECV;
          else if (cnt_d == CNT_LAST)
            state_d = S_DONE;
        end
      end
      S_RECV: begin
        if (fall) begin
          rx_sr_d = {rx_sr_q[14:0], MDIO_IN};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_d == CNT_LAST) begin
            state_d   = S_DONE;
            rd_data_d = rx_sr_d;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
    end
  end

  assign MDIO_OE    = (state_q == S_SEND);
  assign MDIO_OUT   = MDIO_OE & tx_sr_q[31];
  assign BUSY       = (state_q != S_IDLE);
  assign TRANS_DONE = (state_q == S_DONE);
  assign DATA_RDY   = TRANS_DONE & rd_q;
  assign RD_DATA    = rd_data_q;

endmodule
